// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller. 16-bit words, 4 words per line.
// Misses go through a word-serial write-back/fill sequence on a single-word memory port.
module dcache_ctrl #(
  parameter int LINES = 32,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        dreq,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 13 - IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WBACK, S_FILL, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic               wr_q, wr_d;
  logic [15:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]         cnt_q, cnt_d, cnt_nx;
  logic [LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic               mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [15:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic [15:0]        data_q [LINES*WORDS];
  logic [TAG_W-1:0]   tag_q  [LINES];

  logic               data_we, tag_we;
  logic [IDX_W+1:0]   data_waddr;
  logic [15:0]        data_wdat;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         off;
  logic               line_hit;
  logic [15:0]        rd_word;

  function automatic logic [15:0] line_addr(input logic [TAG_W-1:0] t,
                                            input logic [IDX_W-1:0] i,
                                            input logic [1:0]       w);
    return {t, i, w, 1'b0};
  endfunction

  assign idx      = addr_q[2+IDX_W:3];
  assign tag      = addr_q[15:3+IDX_W];
  assign off      = addr_q[2:1];
  assign line_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_word  = data_q[{idx, off}];
  assign cnt_nx   = cnt_q + 2'd1;

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_waddr  = {idx, off};
    data_wdat   = wdata_q;
    tag_we      = 1'b0;
    req_ready   = 1'b0;
    done        = 1'b0;
    hit         = 1'b0;
    dreq        = 1'b0;
    err         = 1'b0;
    rdata       = 16'h0000;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          dreq    = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (addr_q[0]) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = S_IDLE;
        end else if (line_hit) begin
          done = 1'b1;
          hit  = 1'b1;
          if (wr_q) begin
            data_we      = 1'b1;
            dirty_d[idx] = 1'b1;
          end else begin
            rdata = rd_word;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d     = 2'd0;
          mem_req_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            mem_wr_d    = 1'b1;
            mem_addr_d  = line_addr(tag_q[idx], idx, 2'd0);
            mem_wdata_d = data_q[{idx, 2'd0}];
            state_d     = S_WBACK;
          end else begin
            mem_wr_d   = 1'b0;
            mem_addr_d = line_addr(tag, idx, 2'd0);
            state_d    = S_FILL;
          end
        end
      end
      S_WBACK: begin
        if (mem_req_q && mem_ack) begin
          if (cnt_q == 2'd3) begin
            // Drop the request for one cycle between phases; FILL re-issues word 0.
            mem_req_d = 1'b0;
            mem_wr_d  = 1'b0;
            cnt_d     = 2'd0;
            state_d   = S_FILL;
          end else begin
            cnt_d       = cnt_nx;
            mem_addr_d  = line_addr(tag_q[idx], idx, cnt_nx);
            mem_wdata_d = data_q[{idx, cnt_nx}];
          end
        end
      end
      S_FILL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = line_addr(tag, idx, cnt_q);
        end else if (mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {idx, cnt_q};
          data_wdat  = mem_rdata;
          if (cnt_q == 2'd3) begin
            mem_req_d    = 1'b0;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_we       = 1'b1;
            state_d      = S_FINISH;
          end else begin
            cnt_d      = cnt_nx;
            mem_addr_d = line_addr(tag, idx, cnt_nx);
          end
        end
      end
      S_FINISH: begin
        done = 1'b1;
        if (wr_q) begin
          data_we      = 1'b1;
          dirty_d[idx] = 1'b1;
        end else begin
          rdata = rd_word;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Request latch and storage arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (data_we) data_q[data_waddr] <= data_wdat;
    if (tag_we)  tag_q[idx]         <= tag;
  end
endmodule
